// File: rtl/branch_resolve_unit_if.sv
// Resolve-stage bus between the branch comparator side and the PC mux.
// The master drives the candidate branch; the slave (resolve unit) returns the registered result.
interface branch_resolve_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_target;
  logic [XLEN-1:0] in1;
  logic [XLEN-1:0] in2;
  logic [4:0]      br_op;
  logic            in_pred_taken;
  logic            flush;

  logic            out_valid;
  logic            out_taken;
  logic            out_mispredict;
  logic [XLEN-1:0] out_redirect_pc;
  logic            out_illegal;

  modport master (
    output in_valid, in_pc, in_target, in1, in2, br_op, in_pred_taken, flush,
    input  out_valid, out_taken, out_mispredict, out_redirect_pc, out_illegal
  );

  modport slave (
    input  in_valid, in_pc, in_target, in1, in2, br_op, in_pred_taken, flush,
    output out_valid, out_taken, out_mispredict, out_redirect_pc, out_illegal
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Registered branch resolution with a bimodal 2-bit BHT for fetch prediction
// and saturating branch/mispredict statistics.
module branch_resolve_unit #(
  parameter  int XLEN        = 32,
  parameter  int BHT_ENTRIES = 16,
  parameter  int CNT_W       = 16,
  localparam int IDX_W       = $clog2(BHT_ENTRIES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     fetch_pc,
  output logic                fetch_pred_taken,
  branch_resolve_unit_if.slave br,
  output logic [CNT_W-1:0]    branch_count,
  output logic [CNT_W-1:0]    mispredict_count
);

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       bht_d [BHT_ENTRIES];
  logic             valid_q, valid_d;
  logic             taken_q, taken_d;
  logic             mispredict_q, mispredict_d;
  logic             illegal_q, illegal_d;
  logic [XLEN-1:0]  redirect_q, redirect_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;

  logic             is_cond;
  logic             cond_legal;
  logic             cond_taken;
  logic             taken;
  logic             mispredict;
  logic             capture;
  logic             bht_upd;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             unused_fetch_bits;

  assign rd_idx            = fetch_pc[IDX_W+1:2];
  assign wr_idx            = br.in_pc[IDX_W+1:2];
  assign unused_fetch_bits = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0]};
  assign fetch_pred_taken  = bht_q[rd_idx][1];

  always_comb begin
    cond_taken = 1'b0;
    cond_legal = 1'b1;
    case (br.br_op[2:0])
      3'b000:  cond_taken = (br.in1 == br.in2);
      3'b001:  cond_taken = (br.in1 != br.in2);
      3'b100:  cond_taken = ($signed(br.in1) <  $signed(br.in2));
      3'b101:  cond_taken = ($signed(br.in1) >= $signed(br.in2));
      3'b110:  cond_taken = (br.in1 <  br.in2);
      3'b111:  cond_taken = (br.in1 >= br.in2);
      default: cond_legal = 1'b0;
    endcase
    is_cond    = (br.br_op[4:3] == 2'b01);
    taken      = br.br_op[4] | (is_cond & cond_taken);
    mispredict = taken ^ br.in_pred_taken;
    capture    = br.in_valid & ~br.flush;
    bht_upd    = capture & is_cond & cond_legal;
  end

  always_comb begin
    valid_d      = capture;
    taken_d      = taken_q;
    mispredict_d = mispredict_q;
    illegal_d    = illegal_q;
    redirect_d   = redirect_q;
    bcnt_d       = bcnt_q;
    mcnt_d       = mcnt_q;
    bht_d        = bht_q;
    if (capture) begin
      taken_d      = taken;
      mispredict_d = mispredict;
      illegal_d    = is_cond & ~cond_legal;
      redirect_d   = taken ? br.in_target : br.in_pc + XLEN'(4);
      if (mispredict && mcnt_q != '1) mcnt_d = mcnt_q + CNT_W'(1);
    end
    if (bht_upd) begin
      if (bcnt_q != '1) bcnt_d = bcnt_q + CNT_W'(1);
      // Only the written entry changes; a same-cycle fetch read sees bht_q.
      if (cond_taken) begin
        if (bht_q[wr_idx] != 2'b11) bht_d[wr_idx] = bht_q[wr_idx] + 2'd1;
      end else begin
        if (bht_q[wr_idx] != 2'b00) bht_d[wr_idx] = bht_q[wr_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
      illegal_q    <= 1'b0;
      redirect_q   <= '0;
      bcnt_q       <= '0;
      mcnt_q       <= '0;
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else begin
      valid_q      <= valid_d;
      taken_q      <= taken_d;
      mispredict_q <= mispredict_d;
      illegal_q    <= illegal_d;
      redirect_q   <= redirect_d;
      bcnt_q       <= bcnt_d;
      mcnt_q       <= mcnt_d;
      bht_q        <= bht_d;
    end
  end

  assign br.out_valid       = valid_q;
  assign br.out_taken       = taken_q;
  assign br.out_mispredict  = mispredict_q;
  assign br.out_illegal     = illegal_q;
  assign br.out_redirect_pc = redirect_q;
  assign branch_count       = bcnt_q;
  assign mispredict_count   = mcnt_q;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Parametrised branch resolution unit that succeeds the combinational branch comparator. It registers branch resolution by one cycle. It also owns a bimodal branch history table (BHT) of 2-bit saturating counters, which feeds a fetch-side prediction port and is trained at resolve. It reports taken, misprediction and redirect target to the PC mux, and keeps saturating branch and mispredict statistics.

Parameters:
XLEN, 32, operand/PC width in bits
BHT_ENTRIES, 16, number of BHT counters (power of 2, >=2)
CNT_W, 16, width of statistics counters
IDX_W, $clog2(BHT_ENTRIES), derived BHT index width (not overridable)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-high
fetch_pc  input  XLEN  PC being fetched, used for prediction lookup
fetch_pred_taken  output  1  combinational prediction = BHT[fetch_pc[IDX_W+1:2]][1]
in_valid  input  1  branch candidate present this cycle
in_pc  input  XLEN  PC of the instruction
in_target  input  XLEN  computed branch/jump target
in1  input  XLEN  rs1 operand
in2  input  XLEN  rs2 operand
br_op  input  5  branch operation encoding
in_pred_taken  input  1  prediction used at fetch for this instruction
flush  input  1  kill the input this cycle and the registered output
out_valid  output  1  registered result valid
out_taken  output  1  NextPCSrc equivalent, registered
out_mispredict  output  1  out_taken != captured in_pred_taken
out_redirect_pc  output  XLEN  out_taken ? captured target : captured pc+4 (mod 2^XLEN)
out_illegal  output  1  br_op[4:3]==01 with an unlisted low code
branch_count  output  CNT_W  saturating count of resolved conditional branches
mispredict_count  output  CNT_W  saturating count of resolved mispredictions (all kinds)

Behaviour:
- br_op decode, evaluated on the inputs:
  - br_op[4]=1: unconditional, taken=1.
  - br_op[4:3]=00: not a branch, taken=0.
  - br_op[4:3]=01, selected by br_op[2:0]:
    - 000: eq
    - 001: ne
    - 100: signed lt
    - 101: signed ge
    - 110: unsigned lt
    - 111: unsigned ge
    - others (010, 011): taken=0 and illegal=1.
- Capture: on a rising edge with in_valid=1 and flush=0, the stage register loads:
  - out_valid=1
  - taken, illegal, mispredict
  - redirect_pc
- Otherwise out_valid loads 0. The other out_* hold their last values and are don't-care when out_valid=0.
- Latency is exactly 1 cycle. There is no backpressure; the unit accepts every cycle.
- flush=1 at an edge forces out_valid to 0 and suppresses capture, BHT update and counter update for that cycle's input.
- BHT update occurs at the capture edge, only for legal conditional ops (01, listed codes).
  - Index = in_pc[IDX_W+1:2].
  - Taken: counter increments, saturating at 11.
  - Not taken: counter decrements, saturating at 00.
- Unconditional ops and 00 ops never touch the BHT.
- Read/write to the same index in the same cycle: fetch_pred_taken shows the pre-update value. The new value is visible the next cycle.
- Counter increments occur at the capture edge:
  - branch_count increments on legal conditional ops.
  - mispredict_count increments when the capture has mispredict=1.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Reset (async, immediate, valid mid-operation):
  - All BHT entries = 01 (weakly not-taken).
  - out_valid=0, out_taken=0, out_mispredict=0, out_illegal=0, out_redirect_pc=0.
  - branch_count=0, mispredict_count=0.
  - An in-flight capture is discarded.
- A pc+4 carry out of the top bit is dropped: 0xFFFFFFFC+4 = 0x00000000.

Test Plan:
- Reset, then fetch_pc=0x40 -> fetch_pred_taken=0. Assert rst mid-capture -> out_valid=0 immediately and counters return to 0.
- in_valid, br_op=01100, in1=0xFFFFFFFF, in2=1, pred=0, target=0x100, pc=0x20 -> next cycle: out_taken=1, mispredict=1, redirect=0x100, branch_count=1, mispredict_count=1. Same operands with br_op=01110 -> taken=0, redirect=0x24.
- Three consecutive taken beq at pc=0x40 -> BHT[0] goes 01->10->11->11. fetch_pred_taken for 0x40 rises on the cycle after the first update. Then one not-taken -> 10, prediction still 1.
- br_op=10000, pred=0 -> taken=1, mispredict=1, branch_count unchanged, BHT unchanged. br_op=00000, pred=1 -> taken=0, mispredict=1.
- in_valid and flush in the same cycle with a taken beq -> out_valid=0 next cycle, BHT and both counters unchanged. br_op=01010 -> out_illegal=1, taken=0.
- CNT_W=2: five mispredicting captures -> mispredict_count stops at 3. pc=0xFFFFFFFC, not-taken -> redirect=0x0.
